keypad_scanner: RTL and testbench
=================================

# keypad_scanner

Input-side companion to the seven-segment display driver on the calculator board. It multiplexes the 4x4 matrix keypad the same way the display multiplexes its digits: it drives one column low at a time and samples the rows. It debounces over whole scan frames and delivers one key event per press as a 4-bit hex code with a single-cycle strobe. It feeds the calculator input logic and shares the system clock with the display driver.

## Interface

Parameters:
- SCAN_CYCLES, 20000: clock cycles each column is driven (~1 ms at the board clock). Must be >= 4.
- DEBOUNCE_FRAMES, 4: consecutive identical frames required before a state change is accepted. Must be >= 1 and <= 15.

Ports:
- clk  in  1  system clock; everything runs on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- KYPD_COL  out  4  column drive, active-low, exactly one bit low at all times.
- KYPD_ROW  in  4  row sense, active-low (pulled up on board), asynchronous to clk.
- key_code  out  4  hex code of the last accepted key; holds until the next accepted key.
- key_valid  out  1  one-cycle pulse when a new key is accepted.
- key_down  out  1  level; 1 while the accepted key is held.

## Operation

- **Row synchronizer.** KYPD_ROW passes through a 2-flop synchronizer before any use.
- **Scan.**
  - The column index col (0..3) and the dwell timer t (0..SCAN_CYCLES-1) reset to 0.
  - KYPD_COL = ~(1 << col).
  - At t == SCAN_CYCLES-1, the synchronized rows for the current column are captured into a 16-bit frame map at bit col*4+row (pressed = row low). In the same cycle t wraps to 0 and col increments, with 3 wrapping to 0.
- **Key map (col,row -> code).**
  - col0: rows 0..3 = 1,4,7,0
  - col1: 2,5,8,F
  - col2: 3,6,9,E
  - col3: A,B,C,D
- **Frame end.** This is the capture at col 3. The completed map is classified as one of:
  - NONE: no bits set.
  - SINGLE(code): exactly one bit set.
  - MULTI: two or more bits set.
  The map is then cleared for the next frame.
- **Debounce.**
  - If the classification equals the previous frame's classification (for SINGLE this includes the code), the stable count increments, saturating at DEBOUNCE_FRAMES. Otherwise the count is set to 1 and the new classification is stored.
  - Acceptance fires only on the frame where the count first reaches DEBOUNCE_FRAMES.
  - Accepted SINGLE(c): key_code <= c, key_valid pulses, key_down <= 1.
  - Accepted NONE: key_down <= 0, no pulse.
  - Accepted MULTI: no pulse; key_down and key_code unchanged.
- **No auto-repeat.** A held key produces exactly one key_valid. Changing directly from one key to another, with no accepted NONE in between, produces a new event once the new key is stable.

## Timing

- **Reset values:**
  - KYPD_COL = 4'b1110
  - key_code = 0, key_valid = 0, key_down = 0
  - t = 0, col = 0, frame map = 0
  - stored classification = NONE, stable count = 0
- **Reset mid-frame:** the partial map is discarded and scanning restarts at column 0 on the first edge after release.
- **Frame length:** 4*SCAN_CYCLES cycles.
- **key_valid timing:** asserted for exactly the one cycle after the clk edge that captures column 3 of the accepting frame.
- **Press latency:** from a clean press to key_valid is between (DEBOUNCE_FRAMES-1)*4*SCAN_CYCLES+1 and (DEBOUNCE_FRAMES+1)*4*SCAN_CYCLES+3 cycles, including 2 cycles of synchronizer delay.
- **Release latency:** key_down falls on the same frame-end-plus-one cycle timing.
- **Row settling:** column change to sample is SCAN_CYCLES-1 cycles, which covers synchronizer and board settling.

## Test plan

Bench uses SCAN_CYCLES=8 and DEBOUNCE_FRAMES=2, so a frame is 32 cycles. A keypad model pulls row r low while column c is driven low and the key (c,r) is pressed.

- **Reset:** assert reset asynchronously mid-dwell -> KYPD_COL=1110, key_code=0, key_valid=0, key_down=0 immediately, before any clock edge.
- **Scan order:** no keys pressed -> KYPD_COL steps 1110, 1101, 1011, 0111, 1110, changing every 8 cycles; key_valid never asserts.
- **Single press:** hold key (col1,row2) for 5 frames -> exactly one key_valid pulse of one cycle with key_code=8, key_down=1 thereafter.
- **Release:** after the single-press scenario, release the key -> key_down=0 within 3 frames; no key_valid; key_code stays 8.
- **Bounce:** toggle key (col3,row0) press/release every frame for 6 frames, then hold for 3 frames -> no key_valid during toggling, then exactly one pulse with key_code=A.
- **Multi-key then single:** press (col0,row0) and (col2,row1) together for 4 frames -> no key_valid. Then release (col2,row1) -> one pulse with key_code=1.

Source files
------------

// File: rtl/keypad_scanner.sv
`default_nettype none
// keypad_scanner: column-multiplexed 4x4 keypad scan with whole-frame debounce and one hex event per press.
// Rev 1.0
module keypad_scanner #(
  parameter int SCAN_CYCLES     = 20000,
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic       clk,
  input  logic       reset,
  output logic [3:0] KYPD_COL,
  input  logic [3:0] KYPD_ROW,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_down
);

  localparam int            TW       = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam logic [TW-1:0] c_T_LAST = TW'(SCAN_CYCLES - 1);
  localparam logic [3:0]    c_DB     = 4'(DEBOUNCE_FRAMES);

  typedef enum logic [1:0] {
    CLS_NONE   = 2'd0,
    CLS_SINGLE = 2'd1,
    CLS_MULTI  = 2'd2
  } cls_t;

  logic [3:0]    r_row_s1;
  logic [3:0]    r_row_s2;
  logic [TW-1:0] r_t;
  logic [1:0]    r_col;
  logic [15:0]   r_map;
  cls_t          r_cls;
  logic [3:0]    r_cls_code;
  logic [3:0]    r_cnt;

  logic          w_capture;
  logic          w_frame_end;
  logic [15:0]   w_map;
  logic [4:0]    w_ones;
  logic [3:0]    w_idx;
  cls_t          w_cls;
  logic [3:0]    w_code;
  logic          w_same;
  logic [3:0]    w_cnt_next;
  logic          w_accept;

  assign KYPD_COL    = ~(4'b0001 << r_col);
  assign w_capture   = (r_t == c_T_LAST);
  assign w_frame_end = w_capture && (r_col == 2'd3);
  // Pressed rows read low; fold the current column into the frame map at col*4+row.
  assign w_map       = r_map | ({12'd0, ~r_row_s2} << {r_col, 2'b00});

  always_comb begin
    w_ones = '0;
    w_idx  = '0;
    for (int i = 0; i < 16; i++) begin
      if (w_map[i]) begin
        w_ones = w_ones + 5'd1;
        w_idx  = 4'(i);
      end
    end
  end

  always_comb begin
    w_code = 4'h0;
    case (w_idx)
      4'd0:  w_code = 4'h1;
      4'd1:  w_code = 4'h4;
      4'd2:  w_code = 4'h7;
      4'd3:  w_code = 4'h0;
      4'd4:  w_code = 4'h2;
      4'd5:  w_code = 4'h5;
      4'd6:  w_code = 4'h8;
      4'd7:  w_code = 4'hF;
      4'd8:  w_code = 4'h3;
      4'd9:  w_code = 4'h6;
      4'd10: w_code = 4'h9;
      4'd11: w_code = 4'hE;
      4'd12: w_code = 4'hA;
      4'd13: w_code = 4'hB;
      4'd14: w_code = 4'hC;
      default: w_code = 4'hD;
    endcase
  end

  always_comb begin
    if (w_ones == 5'd0) begin
      w_cls = CLS_NONE;
    end else if (w_ones == 5'd1) begin
      w_cls = CLS_SINGLE;
    end else begin
      w_cls = CLS_MULTI;
    end
  end

  assign w_same     = (w_cls == r_cls) && ((w_cls != CLS_SINGLE) || (w_code == r_cls_code));
  assign w_cnt_next = !w_same ? 4'd1 : ((r_cnt < c_DB) ? r_cnt + 4'd1 : r_cnt);
  // Fire only on the frame where the count first reaches the threshold, never while saturated.
  assign w_accept   = (w_cnt_next == c_DB) && !(w_same && (r_cnt == c_DB));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_row_s1   <= 4'hF;
      r_row_s2   <= 4'hF;
      r_t        <= '0;
      r_col      <= 2'd0;
      r_map      <= '0;
      r_cls      <= CLS_NONE;
      r_cls_code <= 4'h0;
      r_cnt      <= 4'd0;
      key_code   <= 4'h0;
      key_valid  <= 1'b0;
      key_down   <= 1'b0;
    end else begin
      r_row_s1  <= KYPD_ROW;
      r_row_s2  <= r_row_s1;
      key_valid <= 1'b0;
      if (w_capture) begin
        r_t   <= '0;
        r_col <= r_col + 2'd1;
        r_map <= w_frame_end ? 16'h0000 : w_map;
      end else begin
        r_t <= r_t + TW'(1);
      end
      if (w_frame_end) begin
        r_cls      <= w_cls;
        r_cls_code <= w_code;
        r_cnt      <= w_cnt_next;
        if (w_accept) begin
          case (w_cls)
            CLS_SINGLE: begin
              key_code  <= w_code;
              key_valid <= 1'b1;
              key_down  <= 1'b1;
            end
            CLS_NONE: key_down <= 1'b0;
            default: ;
          endcase
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// tb_keypad_scanner: randomized frame-level stimulus, keypad matrix model and scoreboard for keypad_scanner.
// Rev 1.0
module tb_keypad_scanner;

  localparam int SC    = 8;
  localparam int DB    = 2;
  localparam int FRAME = 4 * SC;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  KYPD_COL;
  logic [3:0]  KYPD_ROW;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_down;
  logic [15:0] keys = 16'h0000;

  int checks = 0;
  int errors = 0;
  int n      = 0;

  typedef struct packed {
    logic       valid;
    logic [3:0] code;
    logic       down;
  } exp_t;

  exp_t sb[$];

  int key_tab [16] = '{1, 4, 7, 0, 2, 5, 8, 15, 3, 6, 9, 14, 10, 11, 12, 13};

  // Reference state: frame signature -1 = no key, 16 = several keys, else the key's hex value.
  int         m_sig  = -1;
  int         m_cnt  = 0;
  logic [3:0] m_code = 4'h0;
  logic       m_down = 1'b0;

  keypad_scanner #(
    .SCAN_CYCLES     (SC),
    .DEBOUNCE_FRAMES (DB)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .KYPD_COL  (KYPD_COL),
    .KYPD_ROW  (KYPD_ROW),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_down  (key_down)
  );

  always #5 clk = ~clk;

  always_comb begin
    KYPD_ROW = 4'hF;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (!KYPD_COL[c] && keys[c*4+r]) KYPD_ROW[r] = 1'b0;
      end
    end
  end

  task automatic model_reset();
    m_sig  = -1;
    m_cnt  = 0;
    m_code = 4'h0;
    m_down = 1'b0;
  endtask

  // Hold one key pattern for a whole frame and queue what the frame end must show.
  task automatic frame(input logic [15:0] k);
    int   sig;
    int   np;
    bit   acc;
    exp_t e;
    keys = k;
    np   = $countones(k);
    sig  = -1;
    if (np == 1) begin
      for (int i = 0; i < 16; i++) if (k[i]) sig = key_tab[i];
    end else if (np > 1) begin
      sig = 16;
    end
    acc = 1'b0;
    if (sig == m_sig) begin
      if (m_cnt < DB) begin
        m_cnt++;
        acc = (m_cnt == DB);
      end
    end else begin
      m_sig = sig;
      m_cnt = 1;
      acc   = (DB == 1);
    end
    e.valid = 1'b0;
    if (acc) begin
      if (sig == -1) begin
        m_down = 1'b0;
      end else if (sig < 16) begin
        m_code  = sig[3:0];
        m_down  = 1'b1;
        e.valid = 1'b1;
      end
    end
    e.code = m_code;
    e.down = m_down;
    sb.push_back(e);
    repeat (FRAME) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (KYPD_COL !== 4'b1110 || key_code !== 4'h0 || key_valid !== 1'b0 || key_down !== 1'b0) begin
      errors++;
      $display("FAIL %s: col=%b code=%h valid=%b down=%b, want col=1110 code=0 valid=0 down=0",
               tag, KYPD_COL, key_code, key_valid, key_down);
    end
  endtask

  // Monitor: scan order every cycle, scoreboard pop at each frame end, no stray strobes.
  always @(negedge clk) begin
    logic [3:0] exp_col;
    exp_t       e;
    if (reset) begin
      n = 0;
    end else begin
      n++;
      exp_col = 4'hF;
      exp_col[(n / SC) % 4] = 1'b0;
      checks++;
      if (KYPD_COL !== exp_col) begin
        errors++;
        $display("FAIL scan_col cycle %0d: got %b want %b", n, KYPD_COL, exp_col);
      end
      if (n % FRAME == 0) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL frame_end cycle %0d: scoreboard empty, got valid=%b code=%h down=%b",
                   n, key_valid, key_code, key_down);
        end else begin
          e = sb.pop_front();
          if (key_valid !== e.valid || key_code !== e.code || key_down !== e.down) begin
            errors++;
            $display("FAIL frame_end cycle %0d: got valid=%b code=%h down=%b want valid=%b code=%h down=%b",
                     n, key_valid, key_code, key_down, e.valid, e.code, e.down);
          end
        end
      end else begin
        checks++;
        if (key_valid !== 1'b0) begin
          errors++;
          $display("FAIL stray_valid cycle %0d: got key_valid=%b want 0", n, key_valid);
        end
      end
    end
  end

  initial begin
    logic [15:0] m;
    int          kind;
    int          hold;
    int          a;
    int          b;

    #1 check_reset_outputs("reset_init");
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;

    repeat (3) frame(16'h0000);
    repeat (5) frame(16'h0040);
    repeat (3) frame(16'h0000);
    for (int i = 0; i < 6; i++) frame((i % 2 == 0) ? 16'h1000 : 16'h0000);
    repeat (3) frame(16'h1000);
    repeat (2) frame(16'h0000);
    repeat (4) frame(16'h0201);
    repeat (3) frame(16'h0001);
    repeat (2) frame(16'h0000);

    for (int i = 0; i < 30; i++) begin
      kind = $urandom_range(0, 3);
      hold = $urandom_range(1, 4);
      a    = $urandom_range(0, 15);
      b    = (a + 1 + $urandom_range(0, 14)) % 16;
      case (kind)
        0:       m = 16'h0000;
        3:       m = (16'd1 << a) | (16'd1 << b);
        default: m = 16'd1 << a;
      endcase
      repeat (hold) frame(m);
    end

    repeat (3) frame(16'h0040);
    repeat (13) @(negedge clk);
    #2 reset = 1'b1;
    sb.delete();
    model_reset();
    #1 check_reset_outputs("reset_mid");
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;

    repeat (3) frame(16'h8000);
    repeat (3) frame(16'h0000);

    for (int i = 0; i < 3 * FRAME && sb.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
